// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the single physical-memory port between instruction
// fetch (IF) and load/store (LS). One transaction in flight at a time.
// Ties go round-robin, and the winner's request is latched. The memory
// port is driven until mem_ack arrives or the timeout expires. The result
// is returned to the owning requester as a one-cycle rvalid pulse.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   if_req/if_addr           IF read request (held until if_gnt)
//   if_gnt                   IF accepted this cycle (combinational)
//   if_rvalid/rdata/err      IF response (rdata/err hold between pulses)
//   ls_req/we/addr/wdata/wmask  LS request (held until ls_gnt)
//   ls_gnt                   LS accepted this cycle (combinational)
//   ls_rvalid/rdata/err      LS response (rdata=0 for writes and errors)
//   mem_req/we/addr/wdata/wmask  memory request, stable while mem_req=1
//   mem_ack/mem_rdata        memory completion and read data
module pmem_arbiter #(
  parameter int TIMEOUT = 255   // legal range 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [63:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [63:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } mreq_t;

  logic [1:0] state;
  logic       owner, last_owner;
  logic [7:0] cnt;
  mreq_t      req_q;
  logic       tmo;

  // req_q is cleared whenever we leave WAIT, so the memory port reads
  // all-zero outside WAIT without extra gating.
  assign {mem_we, mem_addr, mem_wdata, mem_wmask} = req_q;

  // Fires on the TIMEOUT-th consecutive unacknowledged WAIT cycle.
  assign tmo = ({1'b0, cnt} + 9'd1) == 9'(TIMEOUT);

  // Grants are suppressed while reset is asserted. Otherwise a requester
  // could see a grant for a transaction that the reset edge is about to drop.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst && state == S_IDLE) begin
      if (if_req && (!ls_req || last_owner == OWN_LS)) if_gnt = 1'b1;
      else if (ls_req)                                 ls_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= OWN_LS;
      last_owner <= OWN_LS;
      cnt        <= '0;
      req_q      <= '0;
      mem_req    <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= '0;
      ls_err     <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_gnt || ls_gnt) begin
            state      <= S_WAIT;
            owner      <= ls_gnt;
            last_owner <= ls_gnt;
            cnt        <= '0;
            mem_req    <= 1'b1;
            if (ls_gnt)
              req_q <= '{we: ls_we, addr: ls_addr, wdata: ls_wdata,
                         wmask: (ls_we ? ls_wmask : 8'h00)};
            else
              req_q <= '{we: 1'b0, addr: if_addr, wdata: 64'h0, wmask: 8'h00};
          end
        end
        S_WAIT: begin
          // An ack in the cycle the timeout would fire takes priority.
          if (mem_ack || tmo) begin
            state   <= S_RESP;
            mem_req <= 1'b0;
            req_q   <= '0;
            if (owner == OWN_LS) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= (mem_ack && !req_q.we) ? mem_rdata : 64'h0;
              ls_err    <= !mem_ack;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_ack ? mem_rdata : 64'h0;
              if_err    <= !mem_ack;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter (TIMEOUT=4). A directed vector table
// with hand-derived key outputs runs first. Random traffic follows. Both
// phases are also checked cycle by cycle against a transaction-level model
// that is kept as grant/end timestamps.
module tb_pmem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  always #5 clk = ~clk;

  pmem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction is granted at g_cyc and ends (ack or timeout) at end_cyc.
  // Its response shows at end_cyc+1, and the port is free again at end_cyc+2.
  int          cyc = 0;
  int          g_cyc = -1, end_cyc = -1, resp_cyc = -1;
  bit          t_ls, t_we;
  logic [63:0] t_addr, t_wdata;
  logic [7:0]  t_wmask;
  bit          last_ls = 1'b1;
  logic [63:0] pend_rd;
  bit          pend_err;
  logic [63:0] h_ird = '0, h_lrd = '0;
  bit          h_ierr = 1'b0, h_lerr = 1'b0;
  bit          e_ig, e_lg, e_irv, e_lrv;

  task automatic model_check();
    bit busy, in_wait;
    e_irv = 1'b0;
    e_lrv = 1'b0;
    if (resp_cyc == cyc) begin
      if (t_ls) begin e_lrv = 1'b1; h_lrd = pend_rd; h_lerr = pend_err; end
      else      begin e_irv = 1'b1; h_ird = pend_rd; h_ierr = pend_err; end
    end
    busy    = (g_cyc >= 0) && !((end_cyc >= 0) && (cyc >= end_cyc + 2));
    in_wait = busy && (end_cyc < 0);
    e_ig = !busy && rst && if_req && (!ls_req || last_ls);
    e_lg = !busy && rst && ls_req && (!if_req || !last_ls);

    chk("if_gnt", if_gnt, e_ig);
    chk("ls_gnt", ls_gnt, e_lg);
    chk("mem_req", mem_req, in_wait);
    chk("mem_we", mem_we, in_wait ? t_we : 1'b0);
    chk("mem_addr", mem_addr, in_wait ? t_addr : 64'h0);
    chk("mem_wdata", mem_wdata, in_wait ? t_wdata : 64'h0);
    chk("mem_wmask", mem_wmask, in_wait ? t_wmask : 8'h0);
    chk("if_rvalid", if_rvalid, e_irv);
    chk("ls_rvalid", ls_rvalid, e_lrv);
    chk("if_rdata", if_rdata, h_ird);
    chk("if_err", if_err, h_ierr);
    chk("ls_rdata", ls_rdata, h_lrd);
    chk("ls_err", ls_err, h_lerr);

    if (!rst) begin
      g_cyc = -1; end_cyc = -1; resp_cyc = -1; last_ls = 1'b1;
      h_ird = '0; h_lrd = '0; h_ierr = 1'b0; h_lerr = 1'b0;
    end else begin
      if (in_wait && (mem_ack || (cyc - g_cyc == TO))) begin
        end_cyc  = cyc;
        resp_cyc = cyc + 1;
        pend_err = !mem_ack;
        pend_rd  = (mem_ack && !t_we) ? mem_rdata : 64'h0;
      end
      if (e_ig || e_lg) begin
        g_cyc = cyc; end_cyc = -1; resp_cyc = -1;
        t_ls    = e_lg;
        t_we    = e_lg && ls_we;
        t_addr  = e_lg ? ls_addr : if_addr;
        t_wdata = e_lg ? ls_wdata : 64'h0;
        t_wmask = (e_lg && ls_we) ? ls_wmask : 8'h0;
        last_ls = e_lg;
      end
    end
    cyc++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, ir, lr, lwe, ack;
    logic [63:0] iaddr, laddr, lwd, mrd;
    logic [7:0]  lwm;
    bit eig, elg, emr, eirv, elrv, eerr;
    logic [63:0] erd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(bit rs, bit ir, bit lr, bit lwe, bit ack,
      logic [63:0] iaddr, logic [63:0] laddr, logic [63:0] lwd, logic [7:0] lwm,
      logic [63:0] mrd, bit eig, bit elg, bit emr, bit eirv, bit elrv, bit eerr,
      logic [63:0] erd);
    vec_t r;
    r.rst = rs; r.ir = ir; r.lr = lr; r.lwe = lwe; r.ack = ack;
    r.iaddr = iaddr; r.laddr = laddr; r.lwd = lwd; r.lwm = lwm; r.mrd = mrd;
    r.eig = eig; r.elg = elg; r.emr = emr; r.eirv = eirv; r.elrv = elrv;
    r.eerr = eerr; r.erd = erd;
    return r;
  endfunction

  task automatic apply_inputs(input vec_t r);
    rst = r.rst; if_req = r.ir; if_addr = r.iaddr;
    ls_req = r.lr; ls_we = r.lwe; ls_addr = r.laddr; ls_wdata = r.lwd;
    ls_wmask = r.lwm; mem_ack = r.ack; mem_rdata = r.mrd;
  endtask

  localparam logic [63:0] Z = 64'h0;
  localparam logic [63:0] D0 = 64'h00100073_00000013;

  initial begin
    vec_t r;
    // rs ir lr we ak iaddr laddr lwd lwm mrd | ig lg mr irv lrv err rd
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,0,0,0,0,Z)); // after reset
    vt.push_back(v(1,1,0,0,0, 64'h80000000,Z,Z,0,Z,       1,0,0,0,0,0,Z)); // single IF read
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,1,0,0,0,Z));
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,1,0,0,0,Z));
    vt.push_back(v(1,0,0,0,1, Z,Z,Z,0,D0,                  0,0,1,0,0,0,Z));
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,0,1,0,0,D0));
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,0,0,0,0,Z));
    vt.push_back(v(0,1,1,0,0, 64'h1000,64'h2000,Z,0,Z,     0,0,0,0,0,0,Z)); // reset gates gnt
    vt.push_back(v(1,1,1,0,0, 64'h1000,64'h2000,Z,0,Z,     1,0,0,0,0,0,Z)); // tie -> IF
    vt.push_back(v(1,1,1,0,1, 64'h1008,64'h2000,Z,0,64'hAAAA, 0,0,1,0,0,0,Z));
    vt.push_back(v(1,1,1,0,0, 64'h1008,64'h2000,Z,0,Z,     0,0,0,1,0,0,64'hAAAA));
    vt.push_back(v(1,1,1,0,0, 64'h1008,64'h2000,Z,0,Z,     0,1,0,0,0,0,Z)); // tie -> LS
    vt.push_back(v(1,1,1,0,1, 64'h1008,64'h2008,Z,0,64'hBBBB, 0,0,1,0,0,0,Z));
    vt.push_back(v(1,1,1,0,0, 64'h1008,64'h2008,Z,0,Z,     0,0,0,0,1,0,64'hBBBB));
    vt.push_back(v(1,1,1,0,0, 64'h1008,64'h2008,Z,0,Z,     1,0,0,0,0,0,Z)); // tie -> IF
    vt.push_back(v(1,0,1,0,1, Z,64'h2008,Z,0,64'hCCCC,     0,0,1,0,0,0,Z));
    vt.push_back(v(1,0,1,0,0, Z,64'h2008,Z,0,Z,            0,0,0,1,0,0,64'hCCCC));
    vt.push_back(v(1,0,1,0,0, Z,64'h2008,Z,0,Z,            0,1,0,0,0,0,Z)); // LS
    vt.push_back(v(1,0,0,0,1, Z,Z,Z,0,64'hDDDD,            0,0,1,0,0,0,Z));
    vt.push_back(v(1,0,0,0,1, Z,Z,Z,0,64'h7777,            0,0,0,0,1,0,64'hDDDD)); // ack in RESP
    vt.push_back(v(1,0,0,0,1, Z,Z,Z,0,64'hEEEE,            0,0,0,0,0,0,Z)); // ack in IDLE
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,0,0,0,0,Z));
    vt.push_back(v(1,0,1,1,0, Z,64'h80001000,64'h8765432112345678,8'h03,Z, 0,1,0,0,0,0,Z)); // write
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,1,0,0,0,Z));
    vt.push_back(v(1,0,0,0,1, Z,Z,Z,0,64'hFFFF,            0,0,1,0,0,0,Z));
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,0,0,1,0,Z));
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,0,0,0,0,Z));
    vt.push_back(v(1,0,1,0,0, Z,64'h3000,Z,0,Z,            0,1,0,0,0,0,Z)); // timeout
    for (int i = 0; i < TO; i++)
      vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                 0,0,1,0,0,0,Z));
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,0,0,1,1,Z));
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,0,0,0,0,Z));
    vt.push_back(v(1,0,1,0,0, Z,64'h3008,Z,0,Z,            0,1,0,0,0,0,Z)); // ack in last WAIT
    for (int i = 0; i < TO - 1; i++)
      vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                 0,0,1,0,0,0,Z));
    vt.push_back(v(1,0,0,0,1, Z,Z,Z,0,64'h1234,            0,0,1,0,0,0,Z));
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,0,0,1,0,64'h1234));
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,0,0,0,0,Z));
    vt.push_back(v(1,1,0,0,0, 64'h4000,Z,Z,0,Z,            1,0,0,0,0,0,Z)); // reset mid-WAIT
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,1,0,0,0,Z));
    vt.push_back(v(0,0,0,0,0, Z,Z,Z,0,Z,                   0,0,1,0,0,0,Z));
    for (int i = 0; i < 3; i++)
      vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                 0,0,0,0,0,0,Z));
    vt.push_back(v(1,1,1,0,0, 64'h4008,64'h5000,Z,0,Z,     1,0,0,0,0,0,Z)); // IF wins after reset
    vt.push_back(v(1,0,1,0,1, Z,64'h5000,Z,0,64'h5555,     0,0,1,0,0,0,Z));
    vt.push_back(v(1,0,1,0,0, Z,64'h5000,Z,0,Z,            0,0,0,1,0,0,64'h5555));
    vt.push_back(v(1,0,1,0,0, Z,64'h5000,Z,0,Z,            0,1,0,0,0,0,Z));
    vt.push_back(v(1,0,0,0,1, Z,Z,Z,0,64'h6666,            0,0,1,0,0,0,Z));
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,0,0,1,0,64'h6666));
    vt.push_back(v(1,0,0,0,0, Z,Z,Z,0,Z,                   0,0,0,0,0,0,Z));

    // Initial reset, not compared: DUT state is unknown until it takes effect.
    r = v(0,0,0,0,0, Z,Z,Z,0,Z, 0,0,0,0,0,0,Z);
    apply_inputs(r);
    repeat (2) @(posedge clk);
    #1;

    foreach (vt[i]) begin
      apply_inputs(vt[i]);
      #1;
      chk($sformatf("tbl%0d_if_gnt", i), if_gnt, vt[i].eig);
      chk($sformatf("tbl%0d_ls_gnt", i), ls_gnt, vt[i].elg);
      chk($sformatf("tbl%0d_mem_req", i), mem_req, vt[i].emr);
      chk($sformatf("tbl%0d_if_rvalid", i), if_rvalid, vt[i].eirv);
      chk($sformatf("tbl%0d_ls_rvalid", i), ls_rvalid, vt[i].elrv);
      if (vt[i].eirv) begin
        chk($sformatf("tbl%0d_if_err", i), if_err, vt[i].eerr);
        chk($sformatf("tbl%0d_if_rdata", i), if_rdata, vt[i].erd);
      end
      if (vt[i].elrv) begin
        chk($sformatf("tbl%0d_ls_err", i), ls_err, vt[i].eerr);
        chk($sformatf("tbl%0d_ls_rdata", i), ls_rdata, vt[i].erd);
      end
      model_check();
      @(posedge clk);
      #1;
    end

    // ---------------- randomized traffic ----------------
    if_req = 1'b0;
    ls_req = 1'b0;
    e_ig = 1'b0;
    e_lg = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      // Requests are held until granted, then replaced with a fresh one.
      if (!if_req || e_ig) begin
        if_req  = ($urandom_range(0, 1) == 1);
        if_addr = {$urandom, $urandom};
      end
      if (!ls_req || e_lg) begin
        ls_req   = ($urandom_range(0, 1) == 1);
        ls_we    = ($urandom_range(0, 1) == 1);
        ls_addr  = {$urandom, $urandom};
        ls_wdata = {$urandom, $urandom};
        ls_wmask = 8'($urandom);
      end
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = {$urandom, $urandom};
      rst       = ($urandom_range(0, 199) != 0);
      #1;
      model_check();
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
